// File: rtl/issue_select_pkg.sv
// Shared issue-queue sizing and the per-slot wakeup/select state layout.
package issue_select_pkg;
    localparam int NUM_IQ_ENTRIES      = 8;
    localparam int NUM_IQ_ENTRIES_LOG2 = 3;
    localparam int TAG_W               = 6;

    typedef logic [NUM_IQ_ENTRIES_LOG2-1:0] slot_t;
    typedef logic [TAG_W-1:0]               tag_t;

    // older[i][j] = 1 when slot j is older than slot i
    typedef logic [NUM_IQ_ENTRIES-1:0][NUM_IQ_ENTRIES-1:0] age_mat_t;

    typedef struct packed {
        logic vld;
        logic rdy_a;
        logic rdy_b;
        tag_t src_a;
        tag_t src_b;
        logic alu_only;
    } entry_t;

    function automatic logic tag_hit(input tag_t t, input logic w0, input tag_t t0,
                                     input logic w1, input tag_t t1);
        return (w0 && (t == t0)) || (w1 && (t == t1));
    endfunction
endpackage

// File: rtl/issue_select_if.sv
// Dispatch, wakeup, stall and issue signals between the scheduler and its neighbours.
interface issue_select_if;
    import issue_select_pkg::*;

    logic  flush;
    logic  alloc0, alloc1;
    slot_t alloc_slot0, alloc_slot1;
    tag_t  alloc_src0a, alloc_src0b, alloc_src1a, alloc_src1b;
    logic  alloc_rdy0a, alloc_rdy0b, alloc_rdy1a, alloc_rdy1b;
    logic  alloc_alu_only0, alloc_alu_only1;
    logic  wake0, wake1;
    tag_t  wake_tag0, wake_tag1;
    logic  port_stall0, port_stall1;
    logic  issue0, issue1;
    slot_t issue_slot0, issue_slot1;
    logic [NUM_IQ_ENTRIES-1:0] occupied;
    logic  alloc_err;

    modport master (
        output flush, alloc0, alloc1, alloc_slot0, alloc_slot1,
               alloc_src0a, alloc_src0b, alloc_src1a, alloc_src1b,
               alloc_rdy0a, alloc_rdy0b, alloc_rdy1a, alloc_rdy1b,
               alloc_alu_only0, alloc_alu_only1,
               wake0, wake1, wake_tag0, wake_tag1, port_stall0, port_stall1,
        input  issue0, issue1, issue_slot0, issue_slot1, occupied, alloc_err
    );

    modport slave (
        input  flush, alloc0, alloc1, alloc_slot0, alloc_slot1,
               alloc_src0a, alloc_src0b, alloc_src1a, alloc_src1b,
               alloc_rdy0a, alloc_rdy0b, alloc_rdy1a, alloc_rdy1b,
               alloc_alu_only0, alloc_alu_only1,
               wake0, wake1, wake_tag0, wake_tag1, port_stall0, port_stall1,
        output issue0, issue1, issue_slot0, issue_slot1, occupied, alloc_err
    );
endinterface

// File: rtl/issue_select_oldest_select.sv
// Age-matrix priority picker: the winner is the eligible slot with no eligible slot older than it.
module oldest_select
    import issue_select_pkg::*;
(
    input  logic [NUM_IQ_ENTRIES-1:0] elig,
    input  age_mat_t                  older,
    output logic                      found,
    output slot_t                     idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
            if (!found && elig[i] && ((older[i] & elig) == '0)) begin
                found = 1'b1;
                idx   = slot_t'(i);
            end
        end
    end
endmodule

// File: rtl/issue_select.sv
// Wakeup/select scheduler for the 8-entry issue queue: tracks readiness and age, picks two ports.
module issue_select
    import issue_select_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    issue_select_if.slave bus
);
    localparam int N = NUM_IQ_ENTRIES;

    entry_t [N-1:0] ent_q, ent_d;
    age_mat_t       older_q, older_d;

    logic [N-1:0] vld, elig, alu, elig1, pick0, pick1, issued, a0_oh;
    logic         found0, found1, go0, go1;
    slot_t        idx0, idx1;
    logic         a0_ok, a1_ok, same_slot, err_set;

    logic         issue0_q, issue1_q, alloc_err_q;
    slot_t        issue_slot0_q, issue_slot1_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            vld[i]  = ent_q[i].vld;
            alu[i]  = ent_q[i].alu_only;
            elig[i] = ent_q[i].vld & ent_q[i].rdy_a & ent_q[i].rdy_b;
        end
    end

    oldest_select u_sel0 (.elig(elig), .older(older_q), .found(found0), .idx(idx0));

    assign go0   = found0 & ~bus.port_stall0;
    assign pick0 = go0 ? (N'(1) << idx0) : '0;
    // Port 1 only sees ALU ops, and never the slot port 0 is taking this edge
    assign elig1 = elig & alu & ~pick0;

    oldest_select u_sel1 (.elig(elig1), .older(older_q), .found(found1), .idx(idx1));

    assign go1    = found1 & ~bus.port_stall1;
    assign pick1  = go1 ? (N'(1) << idx1) : '0;
    assign issued = pick0 | pick1;

    // A slot being issued this edge still counts as occupied, so allocating it is dropped
    assign same_slot = bus.alloc0 & bus.alloc1 & (bus.alloc_slot0 == bus.alloc_slot1);
    assign a0_ok     = bus.alloc0 & ~vld[bus.alloc_slot0];
    assign a1_ok     = bus.alloc1 & ~vld[bus.alloc_slot1] & ~same_slot;
    assign err_set   = (bus.alloc0 & ~a0_ok) | (bus.alloc1 & ~a1_ok);
    assign a0_oh     = a0_ok ? (N'(1) << bus.alloc_slot0) : '0;

    always_comb begin
        ent_d   = ent_q;
        older_d = older_q;
        for (int i = 0; i < N; i++) begin
            if (ent_q[i].vld) begin
                ent_d[i].rdy_a = ent_q[i].rdy_a | tag_hit(ent_q[i].src_a, bus.wake0, bus.wake_tag0,
                                                          bus.wake1, bus.wake_tag1);
                ent_d[i].rdy_b = ent_q[i].rdy_b | tag_hit(ent_q[i].src_b, bus.wake0, bus.wake_tag0,
                                                          bus.wake1, bus.wake_tag1);
            end
            if (issued[i]) begin
                ent_d[i].vld   = 1'b0;
                ent_d[i].rdy_a = 1'b0;
                ent_d[i].rdy_b = 1'b0;
            end
        end
        if (a0_ok) begin
            ent_d[bus.alloc_slot0].vld      = 1'b1;
            ent_d[bus.alloc_slot0].src_a    = bus.alloc_src0a;
            ent_d[bus.alloc_slot0].src_b    = bus.alloc_src0b;
            ent_d[bus.alloc_slot0].alu_only = bus.alloc_alu_only0;
            ent_d[bus.alloc_slot0].rdy_a    = bus.alloc_rdy0a | tag_hit(bus.alloc_src0a,
                                              bus.wake0, bus.wake_tag0, bus.wake1, bus.wake_tag1);
            ent_d[bus.alloc_slot0].rdy_b    = bus.alloc_rdy0b | tag_hit(bus.alloc_src0b,
                                              bus.wake0, bus.wake_tag0, bus.wake1, bus.wake_tag1);
            older_d[bus.alloc_slot0] = vld;
            for (int j = 0; j < N; j++) older_d[j][bus.alloc_slot0] = 1'b0;
        end
        if (a1_ok) begin
            ent_d[bus.alloc_slot1].vld      = 1'b1;
            ent_d[bus.alloc_slot1].src_a    = bus.alloc_src1a;
            ent_d[bus.alloc_slot1].src_b    = bus.alloc_src1b;
            ent_d[bus.alloc_slot1].alu_only = bus.alloc_alu_only1;
            ent_d[bus.alloc_slot1].rdy_a    = bus.alloc_rdy1a | tag_hit(bus.alloc_src1a,
                                              bus.wake0, bus.wake_tag0, bus.wake1, bus.wake_tag1);
            ent_d[bus.alloc_slot1].rdy_b    = bus.alloc_rdy1b | tag_hit(bus.alloc_src1b,
                                              bus.wake0, bus.wake_tag0, bus.wake1, bus.wake_tag1);
            // Dispatch 1 is younger than a same-cycle dispatch 0
            older_d[bus.alloc_slot1] = vld | a0_oh;
            for (int j = 0; j < N; j++) older_d[j][bus.alloc_slot1] = 1'b0;
        end
        for (int j = 0; j < N; j++) begin
            if (issued[j]) begin
                for (int i = 0; i < N; i++) older_d[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q         <= '0;
            older_q       <= '0;
            issue0_q      <= 1'b0;
            issue1_q      <= 1'b0;
            issue_slot0_q <= '0;
            issue_slot1_q <= '0;
            alloc_err_q   <= 1'b0;
        end else if (bus.flush) begin
            ent_q         <= '0;
            older_q       <= '0;
            issue0_q      <= 1'b0;
            issue1_q      <= 1'b0;
            issue_slot0_q <= '0;
            issue_slot1_q <= '0;
        end else begin
            ent_q         <= ent_d;
            older_q       <= older_d;
            issue0_q      <= go0;
            issue1_q      <= go1;
            issue_slot0_q <= go0 ? idx0 : '0;
            issue_slot1_q <= go1 ? idx1 : '0;
            alloc_err_q   <= alloc_err_q | err_set;
        end
    end

    assign bus.issue0      = issue0_q;
    assign bus.issue1      = issue1_q;
    assign bus.issue_slot0 = issue_slot0_q;
    assign bus.issue_slot1 = issue_slot1_q;
    assign bus.occupied    = vld;
    assign bus.alloc_err   = alloc_err_q;
endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: hand-computed issue order, wakeup timing, stall, flush, errors, reset.
module tb_issue_select;
    import issue_select_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    issue_select_if bus();
    issue_select dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_iss(input string tag, input bit v0, input int s0, input bit v1, input int s1);
        chk({tag, ".v0"}, 32'(bus.issue0), 32'(v0));
        if (v0) chk({tag, ".s0"}, 32'(bus.issue_slot0), 32'(s0));
        chk({tag, ".v1"}, 32'(bus.issue1), 32'(v1));
        if (v1) chk({tag, ".s1"}, 32'(bus.issue_slot1), 32'(s1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush = 0;
        bus.alloc0 = 0; bus.alloc_slot0 = '0; bus.alloc_src0a = '0; bus.alloc_src0b = '0;
        bus.alloc_rdy0a = 0; bus.alloc_rdy0b = 0; bus.alloc_alu_only0 = 0;
        bus.alloc1 = 0; bus.alloc_slot1 = '0; bus.alloc_src1a = '0; bus.alloc_src1b = '0;
        bus.alloc_rdy1a = 0; bus.alloc_rdy1b = 0; bus.alloc_alu_only1 = 0;
        bus.wake0 = 0; bus.wake_tag0 = '0; bus.wake1 = 0; bus.wake_tag1 = '0;
        bus.port_stall0 = 0; bus.port_stall1 = 0;
    endtask

    task automatic dsp0(input int slot, input int sa, input int sb, input bit ra, input bit rb, input bit alu);
        bus.alloc0 = 1; bus.alloc_slot0 = slot_t'(slot);
        bus.alloc_src0a = tag_t'(sa); bus.alloc_src0b = tag_t'(sb);
        bus.alloc_rdy0a = ra; bus.alloc_rdy0b = rb; bus.alloc_alu_only0 = alu;
    endtask

    task automatic dsp1(input int slot, input int sa, input int sb, input bit ra, input bit rb, input bit alu);
        bus.alloc1 = 1; bus.alloc_slot1 = slot_t'(slot);
        bus.alloc_src1a = tag_t'(sa); bus.alloc_src1b = tag_t'(sb);
        bus.alloc_rdy1a = ra; bus.alloc_rdy1b = rb; bus.alloc_alu_only1 = alu;
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.occ", 32'(bus.occupied), 0);
        chk("rst.err", 32'(bus.alloc_err), 0);
        chk("rst.slot0", 32'(bus.issue_slot0), 0);
        chk_iss("rst", 0, 0, 0, 0);
        reset = 0;

        // Oldest-first on port 0: 3, 5, 1
        dsp0(3, 1, 2, 1, 1, 0); dsp1(5, 3, 4, 1, 1, 0);
        tick(); idle();
        chk("t1.occ1", 32'(bus.occupied), 32'h28);
        chk_iss("t1.e1", 0, 0, 0, 0);
        dsp0(1, 5, 6, 1, 1, 0);
        tick(); idle();
        chk_iss("t1.e2", 1, 3, 0, 0);
        chk("t1.occ2", 32'(bus.occupied), 32'h22);
        tick(); chk_iss("t1.e3", 1, 5, 0, 0);
        tick(); chk_iss("t1.e4", 1, 1, 0, 0);
        chk("t1.occ4", 32'(bus.occupied), 0);
        tick(); chk_iss("t1.e5", 0, 0, 0, 0);

        // Wakeup from a later broadcast; a non-matching tag does nothing
        dsp0(2, 17, 3, 0, 1, 0);
        tick(); idle();
        bus.wake1 = 1; bus.wake_tag1 = 16;
        tick(); idle();
        chk_iss("t2.pre", 0, 0, 0, 0);
        bus.wake0 = 1; bus.wake_tag0 = 17;
        tick(); idle();
        chk_iss("t2.wake", 0, 0, 0, 0);
        tick(); chk_iss("t2.iss", 1, 2, 0, 0);
        tick(); chk_iss("t2.post", 0, 0, 0, 0);

        // Wake in the same cycle as allocation
        dsp1(4, 9, 9, 0, 0, 1); bus.wake1 = 1; bus.wake_tag1 = 9;
        tick(); idle();
        chk("t3.occ", 32'(bus.occupied), 32'h10);
        chk_iss("t3.e1", 0, 0, 0, 0);
        tick(); chk_iss("t3.iss", 1, 4, 0, 0);

        // Port 0 stalled: only the ALU op goes out on port 1
        dsp0(0, 1, 2, 1, 1, 0); dsp1(1, 3, 4, 1, 1, 0);
        tick(); idle();
        dsp0(6, 5, 6, 1, 1, 1); bus.port_stall0 = 1;
        tick(); idle(); bus.port_stall0 = 1;
        chk_iss("t4.s1", 0, 0, 0, 0);
        tick(); idle(); bus.port_stall0 = 1;
        chk_iss("t4.s2", 0, 0, 1, 6);
        tick(); idle();
        chk_iss("t4.s3", 0, 0, 0, 0);
        tick(); chk_iss("t4.r1", 1, 0, 0, 0);
        tick(); chk_iss("t4.r2", 1, 1, 0, 0);
        chk("t4.occ", 32'(bus.occupied), 0);

        // Fill everything, then flush with a colliding alloc and a matching wake
        for (int k = 0; k < 4; k++) begin
            dsp0(2 * k, 20, 21, 0, 0, 0); dsp1(2 * k + 1, 20, 21, 0, 0, 1);
            tick();
        end
        idle();
        chk("t5.full", 32'(bus.occupied), 32'hff);
        chk("t5.err0", 32'(bus.alloc_err), 0);
        bus.flush = 1; dsp0(3, 1, 1, 1, 1, 1);
        bus.wake0 = 1; bus.wake_tag0 = 20;
        tick(); idle();
        chk("t5.occ", 32'(bus.occupied), 0);
        chk("t5.err", 32'(bus.alloc_err), 0);
        chk_iss("t5.f", 0, 0, 0, 0);
        tick();
        chk_iss("t5.f1", 0, 0, 0, 0);
        chk("t5.occ1", 32'(bus.occupied), 0);

        // Allocation into an occupied slot is dropped and sticks alloc_err
        dsp0(7, 30, 31, 0, 1, 0);
        tick(); idle();
        chk("t6.err0", 32'(bus.alloc_err), 0);
        dsp0(7, 40, 41, 1, 1, 1);
        tick(); idle();
        chk("t6.err1", 32'(bus.alloc_err), 1);
        chk("t6.occ", 32'(bus.occupied), 32'h80);
        bus.wake0 = 1; bus.wake_tag0 = 40;
        tick(); idle();
        chk_iss("t6.keep", 0, 0, 0, 0);
        tick(); chk_iss("t6.w40", 0, 0, 0, 0);
        bus.wake0 = 1; bus.wake_tag0 = 30;
        tick(); idle();
        chk_iss("t6.w30", 0, 0, 0, 0);
        tick(); chk_iss("t6.iss", 1, 7, 0, 0);
        chk("t6.errs", 32'(bus.alloc_err), 1);

        // Asynchronous reset while an issue is on the outputs and another entry is pending
        dsp0(0, 1, 2, 1, 1, 0); dsp1(1, 3, 4, 1, 1, 0);
        tick(); idle();
        tick(); chk_iss("t7.pre", 1, 0, 0, 0);
        reset = 1;
        #1;
        chk_iss("t7.rst", 0, 0, 0, 0);
        chk("t7.slot0", 32'(bus.issue_slot0), 0);
        chk("t7.occ", 32'(bus.occupied), 0);
        chk("t7.err", 32'(bus.alloc_err), 0);
        @(negedge clk);
        reset = 0;
        tick(); chk_iss("t7.post", 0, 0, 0, 0);
        chk("t7.occ1", 32'(bus.occupied), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
